// File: rtl/flex_counter_ud.sv
// Bounded up/down counter with runtime bounds, wrap/saturate modes, synchronous
// load and clear, registered boundary/event flags and a saturating wrap counter.
module flex_counter_ud #(
  parameter int unsigned NUM_CNT_BITS  = 4,
  parameter int unsigned WRAP_CNT_BITS = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     load,
  input  logic [NUM_CNT_BITS-1:0]  load_val,
  input  logic                     count_enable,
  input  logic                     count_up,
  input  logic                     saturate,
  input  logic [NUM_CNT_BITS-1:0]  low_val,
  input  logic [NUM_CNT_BITS-1:0]  high_val,
  output logic [NUM_CNT_BITS-1:0]  count_out,
  output logic                     at_high,
  output logic                     at_low,
  output logic                     wrap_flag,
  output logic                     sat_flag,
  output logic                     config_err,
  output logic [WRAP_CNT_BITS-1:0] wrap_cnt
);

  logic                     cfg_bad;
  logic [NUM_CNT_BITS-1:0]  cnt_nxt;
  logic [WRAP_CNT_BITS-1:0] wcnt_nxt;
  logic                     wrap_ev;
  logic                     sat_ev;

  assign cfg_bad = (low_val > high_val);

  always_comb begin
    cnt_nxt  = count_out;
    wcnt_nxt = wrap_cnt;
    wrap_ev  = 1'b0;
    sat_ev   = 1'b0;
    if (clear) begin
      cnt_nxt  = low_val;
      wcnt_nxt = '0;
    end else if (cfg_bad) begin
      cnt_nxt = count_out;
    end else if (load) begin
      if (load_val < low_val)       cnt_nxt = low_val;
      else if (load_val > high_val) cnt_nxt = high_val;
      else                          cnt_nxt = load_val;
    end else if (count_enable) begin
      // Out-of-range counts are pulled back to the nearest bound before any step.
      if (count_out < low_val) begin
        cnt_nxt = low_val;
      end else if (count_out > high_val) begin
        cnt_nxt = high_val;
      end else if (count_up) begin
        if (count_out != high_val) begin
          cnt_nxt = count_out + NUM_CNT_BITS'(1);
        end else if (saturate) begin
          sat_ev = 1'b1;
        end else begin
          cnt_nxt = low_val;
          wrap_ev = 1'b1;
        end
      end else begin
        if (count_out != low_val) begin
          cnt_nxt = count_out - NUM_CNT_BITS'(1);
        end else if (saturate) begin
          sat_ev = 1'b1;
        end else begin
          cnt_nxt = high_val;
          wrap_ev = 1'b1;
        end
      end
    end
    if (wrap_ev && (wrap_cnt != '1)) wcnt_nxt = wrap_cnt + WRAP_CNT_BITS'(1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out  <= '0;
      at_high    <= 1'b0;
      at_low     <= 1'b0;
      wrap_flag  <= 1'b0;
      sat_flag   <= 1'b0;
      config_err <= 1'b0;
      wrap_cnt   <= '0;
    end else begin
      count_out  <= cnt_nxt;
      at_high    <= (cnt_nxt == high_val);
      at_low     <= (cnt_nxt == low_val);
      wrap_flag  <= wrap_ev;
      sat_flag   <= sat_ev;
      config_err <= cfg_bad;
      wrap_cnt   <= wcnt_nxt;
    end
  end

endmodule

// File: tb/tb_flex_counter_ud.sv
// Scoreboard bench for flex_counter_ud: expected states are queued as stimulus
// is applied and compared one clock later.
module tb_flex_counter_ud;

  typedef struct packed {
    logic [3:0] cnt;
    logic       hi;
    logic       lo;
    logic       wf;
    logic       sf;
    logic       ce;
    logic [7:0] wc;
  } obs_t;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       clear = 1'b0, load = 1'b0, count_enable = 1'b0;
  logic       count_up = 1'b1, saturate = 1'b0;
  logic [3:0] load_val = '0, low_val = '0, high_val = '0;

  logic [3:0] count_out, count_out2;
  logic       at_high, at_low, wrap_flag, sat_flag, config_err;
  logic       at_high2, at_low2, wrap_flag2, sat_flag2, config_err2;
  logic [7:0] wrap_cnt;
  logic [1:0] wrap_cnt2;

  obs_t obs, e;
  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  assign obs = {count_out, at_high, at_low, wrap_flag, sat_flag, config_err, wrap_cnt};

  always #5 clk = ~clk;

  flex_counter_ud #(.NUM_CNT_BITS(4), .WRAP_CNT_BITS(8)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .load(load), .load_val(load_val),
    .count_enable(count_enable), .count_up(count_up), .saturate(saturate),
    .low_val(low_val), .high_val(high_val), .count_out(count_out),
    .at_high(at_high), .at_low(at_low), .wrap_flag(wrap_flag), .sat_flag(sat_flag),
    .config_err(config_err), .wrap_cnt(wrap_cnt)
  );

  flex_counter_ud #(.NUM_CNT_BITS(4), .WRAP_CNT_BITS(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .clear(clear), .load(load), .load_val(load_val),
    .count_enable(count_enable), .count_up(count_up), .saturate(saturate),
    .low_val(low_val), .high_val(high_val), .count_out(count_out2),
    .at_high(at_high2), .at_low(at_low2), .wrap_flag(wrap_flag2), .sat_flag(sat_flag2),
    .config_err(config_err2), .wrap_cnt(wrap_cnt2)
  );

  function automatic obs_t mk(input logic [3:0] c, input logic h, input logic l,
                              input logic w, input logic s, input logic ce,
                              input logic [7:0] wc);
    return {c, h, l, w, s, ce, wc};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1 n_rst = 1'b0;
    exp_q.push_back(mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL reset_async: got %h want %h", obs, e); end
    tick(); tick();
    exp_q.push_back(mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    e = exp_q.pop_front(); total++;
    if (obs !== e || wrap_cnt2 !== 2'd0) begin
      bad++; $display("FAIL reset_held: got %h/%0d want %h/0", obs, wrap_cnt2, e);
    end
    n_rst = 1'b1;
  endtask

  task automatic test_wrap_up;
    logic [3:0] c;
    logic [3:0] seq [8] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd2, 4'd3, 4'd4, 4'd5};
    low_val = 4'd2; high_val = 4'd5; saturate = 1'b0; count_up = 1'b1; count_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      c = seq[i];
      exp_q.push_back(mk(c, c == 4'd5, c == 4'd2, i == 4, 1'b0, 1'b0, (i >= 4) ? 8'd1 : 8'd0));
      tick();
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL wrap_up step %0d: got %h want %h", i, obs, e); end
    end
    count_enable = 1'b0;
  endtask

  task automatic test_sat_down;
    logic [3:0] c;
    logic [3:0] seq [5] = '{4'd4, 4'd3, 4'd2, 4'd2, 4'd2};
    saturate = 1'b1; count_up = 1'b0; clear = 1'b1;
    exp_q.push_back(mk(4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0));
    tick(); clear = 1'b0; load = 1'b1; load_val = 4'd5;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL sat_clear: got %h want %h", obs, e); end
    exp_q.push_back(mk(4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    tick(); load = 1'b0; count_enable = 1'b1;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL sat_load5: got %h want %h", obs, e); end
    for (int i = 0; i < 5; i++) begin
      c = seq[i];
      exp_q.push_back(mk(c, 1'b0, c == 4'd2, 1'b0, i >= 3, 1'b0, 8'd0));
      tick();
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL sat_down step %0d: got %h want %h", i, obs, e); end
    end
    count_enable = 1'b0;
    exp_q.push_back(mk(4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0));
    tick();
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL sat_flag_drop: got %h want %h", obs, e); end
  endtask

  task automatic test_load;
    logic [3:0] lv [3] = '{4'd9, 4'd0, 4'd4};
    logic       cl [3] = '{1'b0, 1'b0, 1'b1};
    logic [3:0] ec [3] = '{4'd5, 4'd2, 4'd2};
    saturate = 1'b0; count_up = 1'b1; count_enable = 1'b1; load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load_val = lv[i]; clear = cl[i];
      exp_q.push_back(mk(ec[i], ec[i] == 4'd5, ec[i] == 4'd2, 1'b0, 1'b0, 1'b0, 8'd0));
      tick();
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL load case %0d: got %h want %h", i, obs, e); end
    end
    clear = 1'b0; load = 1'b0; count_enable = 1'b0;
  endtask

  task automatic test_full_range_wrap;
    logic [3:0] c;
    logic [1:0] w2;
    low_val = 4'd0; high_val = 4'd15; saturate = 1'b0; clear = 1'b1;
    exp_q.push_back(mk(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0));
    tick(); clear = 1'b0; count_enable = 1'b1;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL full_clear: got %h want %h", obs, e); end
    for (int i = 0; i < 5; i++) begin
      count_up = i[0];
      c = i[0] ? 4'd0 : 4'd15;
      exp_q.push_back(mk(c, c == 4'd15, c == 4'd0, 1'b1, 1'b0, 1'b0, 8'(i + 1)));
      tick();
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL full_wrap step %0d: got %h want %h", i, obs, e); end
      w2 = (i >= 2) ? 2'd3 : 2'(i + 1);
      total++;
      if (wrap_cnt2 !== w2) begin bad++; $display("FAIL wrap_cnt_sat step %0d: got %0d want %0d", i, wrap_cnt2, w2); end
    end
    count_enable = 1'b0;
    exp_q.push_back(mk(4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5));
    tick();
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL wrap_flag_drop: got %h want %h", obs, e); end
  endtask

  task automatic test_equal_bounds;
    obs_t exps [4];
    logic sats [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    exps[0] = mk(4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
    exps[1] = mk(4'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd6);
    exps[2] = mk(4'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd6);
    exps[3] = mk(4'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd6);
    low_val = 4'd7; high_val = 4'd7; count_up = 1'b1; count_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      saturate = sats[i];
      exp_q.push_back(exps[i]);
      tick();
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL equal_bounds step %0d: got %h want %h", i, obs, e); end
    end
    saturate = 1'b0; count_enable = 1'b0;
  endtask

  task automatic test_config_err;
    low_val = 4'd6; high_val = 4'd3; count_enable = 1'b1; count_up = 1'b1;
    exp_q.push_back(mk(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd6));
    tick(); load = 1'b1; load_val = 4'd4;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL cfg_enable_hold: got %h want %h", obs, e); end
    exp_q.push_back(mk(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd6));
    tick(); clear = 1'b1;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL cfg_load_hold: got %h want %h", obs, e); end
    exp_q.push_back(mk(4'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0));
    tick(); clear = 1'b0; load = 1'b0; count_enable = 1'b0; low_val = 4'd0;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL cfg_clear: got %h want %h", obs, e); end
    exp_q.push_back(mk(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    tick(); count_enable = 1'b1;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL cfg_recover: got %h want %h", obs, e); end
    exp_q.push_back(mk(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    tick(); count_enable = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL cfg_clamp_high: got %h want %h", obs, e); end
  endtask

  task automatic test_bound_change_and_reset;
    low_val = 4'd0; high_val = 4'd5; load = 1'b1; load_val = 4'd4;
    exp_q.push_back(mk(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    tick(); load = 1'b0; count_enable = 1'b1; high_val = 4'd3;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL bc_load4: got %h want %h", obs, e); end
    exp_q.push_back(mk(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    tick(); count_enable = 1'b0; high_val = 4'd5;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL bc_drop_high: got %h want %h", obs, e); end
    exp_q.push_back(mk(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    tick(); count_enable = 1'b1;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL bc_hold_flag: got %h want %h", obs, e); end
    exp_q.push_back(mk(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    tick(); high_val = 4'd4;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL bc_step4: got %h want %h", obs, e); end
    exp_q.push_back(mk(4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1));
    tick();
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL bc_wrap: got %h want %h", obs, e); end
    n_rst = 1'b0;
    exp_q.push_back(mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL mid_reset: got %h want %h", obs, e); end
    tick();
    count_enable = 1'b0; n_rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_load();
    test_full_range_wrap();
    test_equal_bounds();
    test_config_err();
    test_bound_change_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flex_counter_ud.md
# flex_counter_ud

Bounded up/down counter for the datapath control blocks (FIR tap sequencing, SPI bit/byte counting). It generalises the basic flexible counter with several additions:
- Runtime lower and upper bounds.
- Count direction control.
- Selectable wrap or saturate mode.
- Synchronous load.
- Registered boundary and event flags.
- A saturating wrap-event counter.

It sits wherever a sequencer needs a programmable index that may run in either direction.

## Interface
- NUM_CNT_BITS, 4, width of count_out, low_val, high_val, load_val
- WRAP_CNT_BITS, 8, width of wrap_cnt
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear
- load  in  1  synchronous load of load_val
- load_val  in  NUM_CNT_BITS  value to load (unsigned)
- count_enable  in  1  advance one step this cycle
- count_up  in  1  1 = increment, 0 = decrement
- saturate  in  1  1 = hold at bound, 0 = wrap to opposite bound
- low_val  in  NUM_CNT_BITS  lower bound, inclusive, unsigned
- high_val  in  NUM_CNT_BITS  upper bound, inclusive, unsigned
- count_out  out  NUM_CNT_BITS  current count
- at_high  out  1  count_out == high_val
- at_low  out  1  count_out == low_val
- wrap_flag  out  1  one-cycle pulse: a wrap occurred on the last edge
- sat_flag  out  1  one-cycle pulse: a step was blocked by saturation on the last edge
- config_err  out  1  low_val > high_val
- wrap_cnt  out  WRAP_CNT_BITS  number of wraps since reset/clear, saturating

## Operation
- All outputs are registered. Next-state logic is computed from the current count_out and the current inputs.
- **Reset:** count_out = 0, wrap_cnt = 0, and all flags = 0.
- **Priority:** clear > load > count_enable. The action is chosen per cycle.
- **clear:**
  - count_out <= low_val.
  - wrap_cnt <= 0.
  - wrap_flag and sat_flag <= 0.
  - clear is honoured even when config_err = 1.
- **load:** count_out <= load_val, clamped into range.
  - load_val < low_val loads low_val.
  - load_val > high_val loads high_val.
  - No wrap or sat event is generated.
- **Enabled step, count out of range** (bounds changed, or reset value below low_val):
  - count_out < low_val goes to low_val.
  - count_out > high_val goes to high_val.
  - Applies in either direction. No event is generated.
- **Enabled step, count in range:**
  - Up, count < high_val: count + 1.
  - Up, count == high_val, wrap mode: goes to low_val; wrap event.
  - Up, count == high_val, saturate mode: holds; sat event.
  - Down, count > low_val: count − 1.
  - Down, count == low_val, wrap mode: goes to high_val; wrap event.
  - Down, count == low_val, saturate mode: holds; sat event.
- **low_val == high_val:** the count stays at that value.
  - Every enabled step is a wrap event in wrap mode, or a sat event in saturate mode.
- **Arithmetic:** unsigned, NUM_CNT_BITS wide. The count never passes through 2^N−1→0 implicitly. The full range is reached only with low_val = 0 and high_val = all-ones.
- **config_err:** registered as low_val > high_val. While the current low_val > high_val combinationally:
  - load and count_enable are ignored and the count holds.
  - No events are generated.
- **wrap_cnt:** increments on each wrap event and saturates at all-ones.

## Timing
- Latency is one clock for every action. count_out reflects the action on the edge that samples it.
- at_high and at_low are registered from next count_out against the current bounds. A bound change is therefore reflected after the next clock edge, even when the count holds.
- wrap_flag and sat_flag are high for exactly the one cycle following the edge on which the event occurred. With continuous saturated counting, sat_flag stays high every cycle.
- wrap_cnt updates on the same edge as wrap_flag is set.
- Asserting n_rst mid-operation immediately forces the reset values, independent of clk.
- Deassertion is synchronised externally. The first active edge after reset uses the normal rules, so an enabled step from 0 with low_val > 0 goes to low_val.

## Test plan
- Reset, then low=2, high=5, wrap, up, enable held 8 cycles → count 2,3,4,5,2,3,4,5. wrap_flag pulses once after 5→2 and wrap_cnt = 1.
- low=2, high=5, saturate, down from 5, enable 5 cycles → 4,3,2,2,2. sat_flag is high on the two cycles after the blocked steps and wrap_cnt = 0.
- load=1 with load_val=9 and count_enable=1, with low=2, high=5 → count 5 (clamped), at_high = 1, no events. Then clear and load together → count 2 and wrap_cnt = 0.
- low=0, high=15 (NUM_CNT_BITS=4), wrap, down from 0 → 15 with wrap_flag. WRAP_CNT_BITS=2 with 5 wraps → wrap_cnt holds at 3.
- Set low=6, high=3 → config_err = 1 next cycle, and enable/load leave count unchanged. Clear → count 6. Restore low=0 → config_err clears after one edge.
- Counting at count 4, then drop high_val to 3 with enable → count 3, at_high = 1, no wrap. Assert n_rst mid-count → count_out = 0 and all flags 0 immediately.
